// File: rtl/add16_result_checker.sv
// Response monitor for add16bit_fast: recomputes {cout,y} with a bit-serial ripple
// engine (one bit per cycle), reports pass/fail and keeps saturating statistics.
module add16_result_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] y,
  input  logic             cout,
  input  logic             clear,
  output logic             done_valid,
  output logic             pass,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output logic             first_fail_cin
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, REPORT} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_l, b_l, y_l, s;
  logic             cin_l, cout_l, c;
  logic             pass_q;
  logic             match;

  assign match = ({c, s} == {cout_l, y_l});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // pass is live during REPORT and otherwise holds the last verdict
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    done_valid = 1'b0;
    pass       = pass_q;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (idx == IW'(WIDTH - 1)) state_nxt = REPORT;
      end
      REPORT: begin
        done_valid = 1'b1;
        pass       = match;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_l    <= '0;
      b_l    <= '0;
      y_l    <= '0;
      cin_l  <= 1'b0;
      cout_l <= 1'b0;
      s      <= '0;
      c      <= 1'b0;
      idx    <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_l    <= a;
            b_l    <= b;
            y_l    <= y;
            cin_l  <= cin;
            cout_l <= cout;
            c      <= cin;
            idx    <= '0;
          end
        end
        CALC: begin
          s[idx] <= a_l[idx] ^ b_l[idx] ^ c;
          c      <= (a_l[idx] & b_l[idx]) | (a_l[idx] & c) | (b_l[idx] & c);
          idx    <= idx + 1'b1;
        end
        REPORT: pass_q <= match;
        default: ;
      endcase
    end
  end

  // clear has priority over a coincident REPORT update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_count       <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
      first_fail_cin   <= 1'b0;
    end else if (clear) begin
      test_count       <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
      first_fail_cin   <= 1'b0;
    end else if (state == REPORT) begin
      if (test_count != '1) test_count <= test_count + 1'b1;
      if (!match) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_a     <= a_l;
          first_fail_b     <= b_l;
          first_fail_cin   <= cin_l;
        end
      end
    end
  end

endmodule

// File: tb/tb_add16_result_checker.sv
// Self-checking bench for add16_result_checker: directed vectors, clear/reset corner
// cases, random transactions and a streaming in_valid run against an arithmetic model.
module tb_add16_result_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b, y;
  logic        cin, cout;
  logic        clear;
  logic        done_valid;
  logic        pass;
  logic [15:0] test_count, err_count;
  logic        first_fail_valid;
  logic [15:0] first_fail_a, first_fail_b;
  logic        first_fail_cin;

  add16_result_checker #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .y(y), .cout(cout), .clear(clear),
    .done_valid(done_valid), .pass(pass),
    .test_count(test_count), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_a(first_fail_a),
    .first_fail_b(first_fail_b), .first_fail_cin(first_fail_cin)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference state
  int          m_tests, m_errs;
  bit          m_ffv;
  logic [15:0] m_ffa, m_ffb;
  logic        m_ffc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tests = 0; m_errs = 0; m_ffv = 0; m_ffa = '0; m_ffb = '0; m_ffc = 1'b0;
  endtask

  function automatic bit golden_ok(input logic [15:0] ta, input logic [15:0] tb,
                                   input logic tc, input logic [15:0] ty, input logic to);
    int sum;
    sum = int'(ta) + int'(tb) + int'(tc);
    return ({to, ty} == 17'(sum));
  endfunction

  task automatic model_record(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                              input bit ok);
    if (m_tests < 65535) m_tests++;
    if (!ok) begin
      if (m_errs < 65535) m_errs++;
      if (!m_ffv) begin m_ffv = 1; m_ffa = ta; m_ffb = tb; m_ffc = tc; end
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".test_count"}, 32'(test_count), 32'(m_tests));
    chk({tag, ".err_count"},  32'(err_count),  32'(m_errs));
    chk({tag, ".ff_valid"},   32'(first_fail_valid), 32'(m_ffv));
    chk({tag, ".ff_a"},       32'(first_fail_a), 32'(m_ffa));
    chk({tag, ".ff_b"},       32'(first_fail_b), 32'(m_ffb));
    chk({tag, ".ff_cin"},     32'(first_fail_cin), 32'(m_ffc));
  endtask

  // One handshake, then latency/verdict/statistics checks. Optionally clear in REPORT.
  task automatic do_txn(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic [15:0] ty, input logic to,
                        input bit clr_in_report);
    int lat;
    bit ok;
    ok = golden_ok(ta, tb, tc, ty, to);
    @(negedge clk);
    for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
    chk({tag, ".ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = ta; b = tb; cin = tc; y = ty; cout = to;
    @(negedge clk);                // cycle T+1
    in_valid = 1'b0;
    a = ~ta; b = ~tb; y = ~ty;     // latched copies must be used
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!done_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd17);
    chk({tag, ".pass"}, 32'(pass), 32'(ok));
    model_record(ta, tb, tc, ok);
    if (clr_in_report) begin
      clear = 1'b1;
      model_reset();
    end
    @(negedge clk);                // cycle T+18
    clear = 1'b0;
    chk({tag, ".done_pulse"}, 32'(done_valid), 32'd0);
    chk({tag, ".pass_hold"}, 32'(pass), 32'(ok));
    chk({tag, ".ready_after"}, 32'(in_ready), 32'd1);
    chk_stats(tag);
  endtask

  task automatic rand_vec(output logic [15:0] ta, output logic [15:0] tb, output logic tc,
                          output logic [15:0] ty, output logic to);
    logic [16:0] sum;
    ta = 16'($urandom); tb = 16'($urandom); tc = 1'($urandom);
    sum = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
    if ($urandom_range(0, 2) == 0) sum = sum ^ (17'd1 << $urandom_range(0, 16));
    ty = sum[15:0]; to = sum[16];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb, ry;
    logic        rc, ro;
    bit          seen_done;
    int          cyc, last_acc, base_tests;
    bit          q_ok[$];

    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
    a = '0; b = '0; cin = 1'b0; y = '0; cout = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.done_valid", 32'(done_valid), 32'd0);
    chk("reset.pass", 32'(pass), 32'd0);
    chk_stats("reset");
    rst_n = 1'b1;

    do_txn("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
    do_txn("seq1", 16'hffff, 16'hffff, 1'b1, 16'hffff, 1'b1, 0);
    do_txn("seq2", 16'hffff, 16'h0000, 1'b1, 16'h0000, 1'b1, 0);
    do_txn("seq3", 16'h0001, 16'h000e, 1'b1, 16'h0010, 1'b0, 0);
    do_txn("bad1", 16'h0001, 16'h000e, 1'b0, 16'h0010, 1'b0, 0);
    do_txn("bad2", 16'h1234, 16'h4321, 1'b1, 16'h0000, 1'b0, 0);
    do_txn("clr",  16'h00ff, 16'h0001, 1'b0, 16'h0000, 1'b0, 1);

    // reset pulse at T+5 abandons the in-flight check
    @(negedge clk);
    in_valid = 1'b1; a = 16'h0f0f; b = 16'h0101; cin = 1'b0; y = 16'h0000; cout = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid.done_valid", 32'(done_valid), 32'd0);
    chk("rst_mid.pass", 32'(pass), 32'd0);
    chk_stats("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_valid) seen_done = 1;
    end
    chk("rst_mid.no_done", 32'(seen_done), 32'd0);
    chk_stats("rst_mid.after");
    do_txn("post_rst", 16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      rand_vec(ra, rb, rc, ry, ro);
      do_txn($sformatf("rnd%0d", i), ra, rb, rc, ry, ro, 0);
    end

    // streaming: in_valid held high with fresh data every cycle
    @(negedge clk);
    base_tests = m_tests;
    last_acc = -1;
    in_valid = 1'b1;
    for (cyc = 0; cyc < 18 * 6; cyc++) begin
      if (done_valid) begin
        chk("stream.pending", 32'(q_ok.size() > 0), 32'd1);
        if (q_ok.size() > 0) chk("stream.pass", 32'(pass), 32'(q_ok.pop_front()));
      end
      rand_vec(ra, rb, rc, ry, ro);
      a = ra; b = rb; cin = rc; y = ry; cout = ro;
      if (in_ready) begin
        if (last_acc >= 0) chk("stream.gap", 32'(cyc - last_acc), 32'd18);
        last_acc = cyc;
        q_ok.push_back(golden_ok(ra, rb, rc, ry, ro));
        model_record(ra, rb, rc, golden_ok(ra, rb, rc, ry, ro));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 40 && q_ok.size() > 0; k++) begin
      if (done_valid) chk("stream.pass", 32'(pass), 32'(q_ok.pop_front()));
      @(negedge clk);
    end
    chk("stream.drained", 32'(q_ok.size()), 32'd0);
    chk("stream.accepted", 32'(m_tests - base_tests), 32'd6);
    chk_stats("stream");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
